// File: rtl/events_apb_pkg.sv
// +----------------------------------------------------------------------------+
// | events_apb_pkg : address map, bus state and source codes shared by the     |
// |                  event-to-APB master and the APB event logger.             |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

package events_apb_pkg;

  localparam logic [31:0] A_ADDR   = 32'hABBA_0000;
  localparam logic [31:0] B_ADDR   = 32'hBAFF_0000;
  localparam logic [31:0] C_ADDR   = 32'hCAFE_0000;
  localparam logic [31:0] CLR_ADDR = 32'hC1EA_0000;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;
  localparam logic [1:0] SRC_C    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------------+
// | sat_counter : up-counter that holds at all-ones instead of wrapping.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/apb_event_logger.sv
// +----------------------------------------------------------------------------+
// | apb_event_logger : APB completer counting event writes per source, with    |
// |                    programmable wait states and error response.            |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module apb_event_logger
  import events_apb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apb_psel_i,
  input  logic             apb_penable_i,
  input  logic [31:0]      apb_paddr_i,
  input  logic             apb_pwrite_i,
  input  logic [31:0]      apb_pwdata_i,
  output logic             apb_pready_o,
  output logic [31:0]      apb_prdata_o,
  output logic             apb_pslverr_o,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o,
  output logic [CNT_W-1:0] cnt_c_o,
  output logic [31:0]      last_pwdata_o,
  output logic [1:0]       last_src_o,
  output logic             err_pulse_o
);

  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  apb_state_t       r_state;
  apb_state_t       w_state_nxt;
  logic [3:0]       r_wait;
  logic [3:0]       w_wait_nxt;
  logic             w_setup;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_write;
  logic [31:0]      r_last_pwdata;
  logic [1:0]       r_last_src;
  logic             r_err_pulse;
  logic             w_pready;
  logic             w_complete;
  logic             w_hit_a;
  logic             w_hit_b;
  logic             w_hit_c;
  logic             w_hit_clr;
  logic             w_mapped;
  logic             w_clr;
  logic [2:0]       w_inc;
  logic [CNT_W-1:0] w_cnt [3];

  assign w_hit_a   = (r_addr == A_ADDR);
  assign w_hit_b   = (r_addr == B_ADDR);
  assign w_hit_c   = (r_addr == C_ADDR);
  assign w_hit_clr = (r_addr == CLR_ADDR);
  assign w_mapped  = w_hit_a | w_hit_b | w_hit_c | w_hit_clr;

  // pready comes from registered state only, so WAIT_CYCLES=0 completes in one access cycle
  assign w_pready   = (r_state == ACCESS) && (r_wait == 4'd0);
  assign w_complete = w_pready && apb_psel_i && apb_penable_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_setup     = 1'b0;
    case (r_state)
      IDLE: begin
        if (apb_psel_i && !apb_penable_i) begin
          w_state_nxt = ACCESS;
          w_wait_nxt  = C_WAIT;
          w_setup     = 1'b1;
        end
      end
      ACCESS: begin
        if (!apb_psel_i) begin
          w_state_nxt = IDLE;
        end else begin
          if (r_wait != 4'd0) begin
            w_wait_nxt = r_wait - 4'd1;
          end
          if (w_complete) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_write <= 1'b0;
    end else if (w_setup) begin
      r_addr  <= apb_paddr_i;
      r_wdata <= apb_pwdata_i;
      r_write <= apb_pwrite_i;
    end
  end

  assign w_clr = w_complete && r_write && w_hit_clr;
  assign w_inc = {3{w_complete && r_write}} & {w_hit_c, w_hit_b, w_hit_a};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_inc[gi]),
      .i_clr   (w_clr),
      .o_count (w_cnt[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_pwdata <= 32'd0;
      r_last_src    <= SRC_NONE;
      r_err_pulse   <= 1'b0;
    end else begin
      r_err_pulse <= w_complete && !w_mapped;
      if (w_clr) begin
        r_last_pwdata <= 32'd0;
        r_last_src    <= SRC_NONE;
      end else if (w_inc != 3'b000) begin
        r_last_pwdata <= r_wdata;
        r_last_src    <= w_hit_a ? SRC_A : (w_hit_b ? SRC_B : SRC_C);
      end
    end
  end

  always_comb begin
    apb_prdata_o = 32'd0;
    if (w_pready && !r_write) begin
      if (w_hit_a) begin
        apb_prdata_o = 32'(w_cnt[0]);
      end else if (w_hit_b) begin
        apb_prdata_o = 32'(w_cnt[1]);
      end else if (w_hit_c) begin
        apb_prdata_o = 32'(w_cnt[2]);
      end else if (w_hit_clr) begin
        apb_prdata_o = {30'd0, r_last_src};
      end
    end
  end

  assign apb_pready_o  = w_pready;
  assign apb_pslverr_o = w_pready && !w_mapped;
  assign cnt_a_o       = w_cnt[0];
  assign cnt_b_o       = w_cnt[1];
  assign cnt_c_o       = w_cnt[2];
  assign last_pwdata_o = r_last_pwdata;
  assign last_src_o    = r_last_src;
  assign err_pulse_o   = r_err_pulse;

endmodule

`default_nettype wire
